// File: rtl/cam_pix_pipe.sv
// cam_pix_pipe: camera parallel-bus pixel pipeline.
// The input registers are followed by three stages: capture, filter and output.
// - Capture assembles and decodes byte pairs, or takes RAW samples.
// - Filter applies the RGB weighted sum and shift.
// - Output holds a valid/ready register toward the FIFO.
// Optional build macro: CAM_PIX_DECIM_EN enables column/row decimation.
module cam_pix_pipe #(
    parameter int DATA_WIDTH = 12,
    parameter int SHIFT_MAX  = 9
) (
    input  logic                  s_cam_clk_dft,
    input  logic                  rstn_i,
    input  logic                  cfg_en_i,
    input  logic [2:0]            cfg_format_i,
    input  logic [3:0]            cfg_shift_i,
    input  logic [7:0]            cfg_coeff_r_i,
    input  logic [7:0]            cfg_coeff_g_i,
    input  logic [7:0]            cfg_coeff_b_i,
    input  logic                  cfg_framedrop_en_i,
    input  logic [5:0]            cfg_framedrop_val_i,
    input  logic                  cfg_slice_en_i,
    input  logic [15:0]           cfg_llx_i,
    input  logic [15:0]           cfg_lly_i,
    input  logic [15:0]           cfg_urx_i,
    input  logic [15:0]           cfg_ury_i,
    input  logic [15:0]           cfg_rowlen_i,
    input  logic [3:0]            cfg_decim_i,
    input  logic [DATA_WIDTH-1:0] cam_data_i,
    input  logic                  cam_hsync_i,
    input  logic                  cam_vsync_i,
    output logic [15:0]           pix_data_o,
    output logic                  pix_valid_o,
    input  logic                  pix_ready_i,
    output logic                  ovf_o,
    output logic                  frame_done_o
);

    localparam logic [2:0] FMT_RGB565 = 3'b000;
    localparam logic [2:0] FMT_RGB555 = 3'b001;
    localparam logic [2:0] FMT_RGB444 = 3'b010;
    localparam logic [2:0] FMT_BYP_BE = 3'b100;
    localparam logic [2:0] FMT_BYP_LE = 3'b101;
    localparam logic [2:0] FMT_RAW    = 3'b110;
    localparam logic [4:0] SHIFT_LIM  = 5'(SHIFT_MAX);

    logic                  en_meta, en_s, active;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  hs_q, vs_q, vs_qq;
    logic                  phase_lsb;
    logic [7:0]            msb_q;
    logic [15:0]           col_cnt, row_cnt;
    logic [5:0]            frame_cnt;

    logic                  s1_valid, s1_rgb;
    logic [7:0]            s1_r, s1_g, s1_b;
    logic [15:0]           s1_word;
    logic                  s2_valid;
    logic [15:0]           s2_data;

    logic                  sof, eof;
    logic                  fmt_byte, fmt_raw, is_rgb;
    logic                  pix_done, in_win, decim_ok, keep;
    logic [7:0]            dec_r, dec_g, dec_b;
    logic [15:0]           dec_word, byte_word;
    logic [15:0]           prod_r, prod_g, prod_b;
    logic [16:0]           filt_sum;
    logic [3:0]            shift_eff;
    logic [15:0]           filt_data;

    assign sof = vs_q & ~vs_qq;
    assign eof = ~vs_q & vs_qq;
    assign byte_word = {msb_q, data_q[7:0]};

    // Format classification and decode of the registered sample (plus stored MSB).
    always_comb begin
        fmt_byte = 1'b0;
        fmt_raw  = 1'b0;
        is_rgb   = 1'b0;
        dec_r    = '0;
        dec_g    = '0;
        dec_b    = '0;
        dec_word = '0;
        case (cfg_format_i)
            FMT_RGB565: begin
                fmt_byte = 1'b1;
                is_rgb   = 1'b1;
                dec_r    = {byte_word[15:11], 3'b000};
                dec_g    = {byte_word[10:5], 2'b00};
                dec_b    = {byte_word[4:0], 3'b000};
            end
            FMT_RGB555: begin
                fmt_byte = 1'b1;
                is_rgb   = 1'b1;
                dec_r    = {byte_word[14:10], 3'b000};
                dec_g    = {byte_word[9:5], 3'b000};
                dec_b    = {byte_word[4:0], 3'b000};
            end
            FMT_RGB444: begin
                fmt_byte = 1'b1;
                is_rgb   = 1'b1;
                dec_r    = {msb_q[3:0], 4'b0000};
                dec_g    = {data_q[7:4], 4'b0000};
                dec_b    = {data_q[3:0], 4'b0000};
            end
            FMT_BYP_BE: begin
                fmt_byte = 1'b1;
                dec_word = byte_word;
            end
            FMT_BYP_LE: begin
                fmt_byte = 1'b1;
                dec_word = {data_q[7:0], msb_q};
            end
            FMT_RAW: begin
                fmt_raw = 1'b1;
                dec_word[DATA_WIDTH-1:0] = data_q;
            end
            default: ;
        endcase
    end

    // Pixel completion, window and decimation gating.
    always_comb begin
        pix_done = active & hs_q & (fmt_raw | (fmt_byte & phase_lsb));
        in_win   = (col_cnt >= cfg_llx_i) && (col_cnt <= cfg_urx_i) &&
                   (row_cnt >= cfg_lly_i) && (row_cnt <= cfg_ury_i);
`ifdef CAM_PIX_DECIM_EN
        decim_ok = ((col_cnt & ((16'd1 << cfg_decim_i[1:0]) - 16'd1)) == 16'd0) &&
                   ((row_cnt & ((16'd1 << cfg_decim_i[3:2]) - 16'd1)) == 16'd0);
`else
        decim_ok = 1'b1;
`endif
        keep = pix_done && (frame_cnt == 6'd0) && (in_win || !cfg_slice_en_i) && decim_ok;
    end

`ifndef CAM_PIX_DECIM_EN
    logic unused_decim;
    assign unused_decim = ^cfg_decim_i;
`endif

    // Weighted RGB sum (17-bit wrap), then right shift; out-of-range shifts act as 0.
    always_comb begin
        prod_r    = 16'(s1_r) * 16'(cfg_coeff_r_i);
        prod_g    = 16'(s1_g) * 16'(cfg_coeff_g_i);
        prod_b    = 16'(s1_b) * 16'(cfg_coeff_b_i);
        filt_sum  = {1'b0, prod_r} + {1'b0, prod_g} + {1'b0, prod_b};
        shift_eff = ({1'b0, cfg_shift_i} > SHIFT_LIM) ? 4'd0 : cfg_shift_i;
        filt_data = 16'(filt_sum >> shift_eff);
    end

    // Two-flop synchronizer for the enable coming from the system domain.
    always_ff @(posedge s_cam_clk_dft or negedge rstn_i) begin
        if (!rstn_i) begin
            en_meta <= 1'b0;
            en_s    <= 1'b0;
        end else begin
            en_meta <= cfg_en_i;
            en_s    <= en_meta;
        end
    end

    // Input registers for the sensor bus; vs_qq gives the vsync edge detect.
    always_ff @(posedge s_cam_clk_dft or negedge rstn_i) begin
        if (!rstn_i) begin
            data_q <= '0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            vs_qq  <= 1'b0;
        end else begin
            data_q <= cam_data_i;
            hs_q   <= cam_hsync_i;
            vs_q   <= cam_vsync_i;
            vs_qq  <= vs_q;
        end
    end

    // Active starts only at a frame start and drops as soon as the enable is gone.
    always_ff @(posedge s_cam_clk_dft or negedge rstn_i) begin
        if (!rstn_i)    active <= 1'b0;
        else if (!en_s) active <= 1'b0;
        else if (sof)   active <= 1'b1;
    end

    // Byte-pair phase: first hsync-high sample is the MSB, stored for the LSB.
    always_ff @(posedge s_cam_clk_dft or negedge rstn_i) begin
        if (!rstn_i) begin
            phase_lsb <= 1'b0;
            msb_q     <= '0;
        end else if (!active || !hs_q) begin
            phase_lsb <= 1'b0;
        end else if (fmt_byte) begin
            if (!phase_lsb) msb_q <= data_q[7:0];
            phase_lsb <= ~phase_lsb;
        end
    end

    // Column/row position of each completed pixel, wrapping at the row length.
    always_ff @(posedge s_cam_clk_dft or negedge rstn_i) begin
        if (!rstn_i) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (!active || sof) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (pix_done) begin
            if (col_cnt == cfg_rowlen_i) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + 16'd1;
            end else begin
                col_cnt <= col_cnt + 16'd1;
            end
        end
    end

    // Frame counter: only frame index 0 of each drop cycle is kept.
    always_ff @(posedge s_cam_clk_dft or negedge rstn_i) begin
        if (!rstn_i)                 frame_cnt <= '0;
        else if (!active)            frame_cnt <= '0;
        else if (sof) begin
            if (!cfg_framedrop_en_i)                    frame_cnt <= '0;
            else if (frame_cnt >= cfg_framedrop_val_i)  frame_cnt <= '0;
            else                                        frame_cnt <= frame_cnt + 6'd1;
        end
    end

    // Stage 1 (capture): register decoded pixel when it is kept.
    always_ff @(posedge s_cam_clk_dft or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_valid <= 1'b0;
            s1_rgb   <= 1'b0;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
            s1_word  <= '0;
        end else begin
            s1_valid <= keep;
            if (keep) begin
                s1_rgb  <= is_rgb;
                s1_r    <= dec_r;
                s1_g    <= dec_g;
                s1_b    <= dec_b;
                s1_word <= dec_word;
            end
        end
    end

    // Stage 2 (filter): RGB through the weighted sum, other formats pass through.
    always_ff @(posedge s_cam_clk_dft or negedge rstn_i) begin
        if (!rstn_i) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid & active;
            if (s1_valid) s2_data <= s1_rgb ? filt_data : s1_word;
        end
    end

    // Stage 3 (output). Handshake: a pixel transfers on a clock edge where
    // pix_valid_o and pix_ready_i are both high; while pix_ready_i is low,
    // pix_valid_o and pix_data_o stay stable. A stage-2 pixel that finds the
    // register still held (valid and not ready) is dropped.
    always_ff @(posedge s_cam_clk_dft or negedge rstn_i) begin
        if (!rstn_i) begin
            pix_valid_o <= 1'b0;
            pix_data_o  <= '0;
        end else if (!active) begin
            pix_valid_o <= 1'b0;
        end else if (s2_valid) begin
            if (!pix_valid_o || pix_ready_i) begin
                pix_valid_o <= 1'b1;
                pix_data_o  <= s2_data;
            end
        end else if (pix_ready_i) begin
            pix_valid_o <= 1'b0;
        end
    end

    // Sticky overflow on a dropped pixel, cleared per frame and while inactive.
    always_ff @(posedge s_cam_clk_dft or negedge rstn_i) begin
        if (!rstn_i)                                       ovf_o <= 1'b0;
        else if (!active || sof)                           ovf_o <= 1'b0;
        else if (s2_valid && pix_valid_o && !pix_ready_i)  ovf_o <= 1'b1;
    end

    // One-cycle end-of-frame pulse on vsync falling edge.
    always_ff @(posedge s_cam_clk_dft or negedge rstn_i) begin
        if (!rstn_i) frame_done_o <= 1'b0;
        else         frame_done_o <= active & eof;
    end

endmodule

// File: tb/tb_cam_pix_pipe.sv
// Testbench for cam_pix_pipe: directed steps plus randomized frames
// checked against a behavioural pixel model and an expected-pixel queue.
module tb_cam_pix_pipe;
  localparam int DW = 12;
  localparam int SHIFT_MAX = 9;

  logic          s_cam_clk_dft = 1'b0;
  logic          rstn_i;
  logic          cfg_en_i;
  logic [2:0]    cfg_format_i;
  logic [3:0]    cfg_shift_i;
  logic [7:0]    cfg_coeff_r_i, cfg_coeff_g_i, cfg_coeff_b_i;
  logic          cfg_framedrop_en_i;
  logic [5:0]    cfg_framedrop_val_i;
  logic          cfg_slice_en_i;
  logic [15:0]   cfg_llx_i, cfg_lly_i, cfg_urx_i, cfg_ury_i, cfg_rowlen_i;
  logic [3:0]    cfg_decim_i;
  logic [DW-1:0] cam_data_i;
  logic          cam_hsync_i, cam_vsync_i;
  logic [15:0]   pix_data_o;
  logic          pix_valid_o;
  logic          pix_ready_i;
  logic          ovf_o;
  logic          frame_done_o;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  // clock / reset block
  always #5 s_cam_clk_dft = ~s_cam_clk_dft;

  cam_pix_pipe #(.DATA_WIDTH(DW), .SHIFT_MAX(SHIFT_MAX)) dut (
    .s_cam_clk_dft(s_cam_clk_dft), .rstn_i(rstn_i), .cfg_en_i(cfg_en_i),
    .cfg_format_i(cfg_format_i), .cfg_shift_i(cfg_shift_i),
    .cfg_coeff_r_i(cfg_coeff_r_i), .cfg_coeff_g_i(cfg_coeff_g_i), .cfg_coeff_b_i(cfg_coeff_b_i),
    .cfg_framedrop_en_i(cfg_framedrop_en_i), .cfg_framedrop_val_i(cfg_framedrop_val_i),
    .cfg_slice_en_i(cfg_slice_en_i), .cfg_llx_i(cfg_llx_i), .cfg_lly_i(cfg_lly_i),
    .cfg_urx_i(cfg_urx_i), .cfg_ury_i(cfg_ury_i), .cfg_rowlen_i(cfg_rowlen_i),
    .cfg_decim_i(cfg_decim_i), .cam_data_i(cam_data_i), .cam_hsync_i(cam_hsync_i),
    .cam_vsync_i(cam_vsync_i), .pix_data_o(pix_data_o), .pix_valid_o(pix_valid_o),
    .pix_ready_i(pix_ready_i), .ovf_o(ovf_o), .frame_done_o(frame_done_o)
  );

  // monitor: record accepted pixels and end-of-frame pulses
  always @(negedge s_cam_clk_dft) begin
    if (rstn_i === 1'b1 && pix_valid_o && pix_ready_i) got_q.push_back(pix_data_o);
    if (rstn_i === 1'b1 && frame_done_o) fd_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge s_cam_clk_dft);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] d);
    cam_hsync_i = 1'b1;
    cam_data_i  = d;
    cyc(1);
  endtask

  task automatic line_end();
    cam_hsync_i = 1'b0;
    cam_data_i  = '0;
    cyc(3);
  endtask

  task automatic sof_frame();
    cam_vsync_i = 1'b1;
    cyc(4);
  endtask

  task automatic eof_frame();
    cam_hsync_i = 1'b0;
    cam_vsync_i = 1'b0;
    cyc(4);
  endtask

  task automatic enable_cycle();
    cfg_en_i = 1'b0;
    cyc(6);
    cfg_en_i = 1'b1;
    cyc(4);
  endtask

  // scoreboard: compare recorded stream with expected queue, then empty both
  task automatic compare_stream(input string tag);
    cyc(8);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check(tag, got_q[i], exp_q[i]);
    exp_q.delete();
    got_q.delete();
  endtask

  // behavioural model of one byte-pair pixel
  function automatic logic [15:0] model_byte(input int fmt, input int msb, input int lsb,
                                             input int cr, input int cg, input int cb,
                                             input int shift);
    int w, r, g, b, sum, sh;
    w = msb * 256 + lsb;
    r = 0; g = 0; b = 0;
    case (fmt)
      0: begin r = (w / 2048) * 8; g = ((w / 32) % 64) * 4; b = (w % 32) * 8; end
      1: begin r = ((w / 1024) % 32) * 8; g = ((w / 32) % 32) * 8; b = (w % 32) * 8; end
      2: begin r = (msb % 16) * 16; g = (lsb / 16) * 16; b = (lsb % 16) * 16; end
      4: return 16'(w);
      5: return 16'(lsb * 256 + msb);
      default: return 16'(0);
    endcase
    sum = (r * cr + g * cg + b * cb) % 131072;
    sh  = (shift > SHIFT_MAX) ? 0 : shift;
    return 16'((sum >> sh) % 65536);
  endfunction

  initial begin
    int fmt, n, prev, d, fd0, d0, d1;

    // reset
    rstn_i = 1'b0; cfg_en_i = 1'b0; cfg_format_i = 3'd0; cfg_shift_i = 4'd0;
    cfg_coeff_r_i = 8'd1; cfg_coeff_g_i = 8'd0; cfg_coeff_b_i = 8'd0;
    cfg_framedrop_en_i = 1'b0; cfg_framedrop_val_i = 6'd0; cfg_slice_en_i = 1'b0;
    cfg_llx_i = '0; cfg_lly_i = '0; cfg_urx_i = '0; cfg_ury_i = '0;
    cfg_rowlen_i = 16'hFFFF; cfg_decim_i = 4'd0;
    cam_data_i = '0; cam_hsync_i = 1'b0; cam_vsync_i = 1'b0; pix_ready_i = 1'b1;
    cyc(3);
    check("rst_valid", pix_valid_o, 0);
    check("rst_data", pix_data_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_fdone", frame_done_o, 0);
    rstn_i = 1'b1;

    // RGB565 latency: MSB 0xF8, LSB 0x1F, coeffs 1/0/0, shift 0
    cfg_en_i = 1'b1;
    cyc(4);
    sof_frame();
    send(12'h0F8);
    cam_hsync_i = 1'b1; cam_data_i = 12'h01F;
    @(posedge s_cam_clk_dft); #1;
    cam_hsync_i = 1'b0; cam_data_i = '0;
    cyc(1); check("rgb565_lat1", pix_valid_o, 0);
    cyc(1); check("rgb565_lat2", pix_valid_o, 0);
    cyc(1); check("rgb565_lat3_valid", pix_valid_o, 1);
    check("rgb565_data", pix_data_o, 16'h00F8);
    cyc(2); got_q.delete();

    // RAW back-to-back samples
    cfg_format_i = 3'b110;
    cyc(2);
    send(12'hABC);
    send(12'h123);
    cam_hsync_i = 1'b0;
    cyc(1); check("raw_lat2", pix_valid_o, 0);
    cyc(1); check("raw_v0", pix_valid_o, 1); check("raw_d0", pix_data_o, 16'h0ABC);
    cyc(1); check("raw_v1", pix_valid_o, 1); check("raw_d1", pix_data_o, 16'h0123);
    cyc(3); got_q.delete();
    eof_frame();

    // randomized frames, all formats
    for (int f = 0; f < 6; f++) begin
      fmt = $urandom_range(0, 7);
      cfg_format_i  = 3'(fmt);
      cfg_coeff_r_i = 8'($urandom_range(0, 255));
      cfg_coeff_g_i = 8'($urandom_range(0, 255));
      cfg_coeff_b_i = 8'($urandom_range(0, 255));
      cfg_shift_i   = 4'($urandom_range(0, 15));
      sof_frame();
      for (int l = 0; l < 3; l++) begin
        n = $urandom_range(1, 9);
        prev = 0;
        for (int i = 0; i < n; i++) begin
          d = $urandom_range(0, 4095);
          send(DW'(d));
          if (fmt == 6) exp_q.push_back(16'(d));
          else if (fmt != 3 && fmt != 7 && (i % 2) == 1)
            exp_q.push_back(model_byte(fmt, prev % 256, d % 256, cfg_coeff_r_i,
                                       cfg_coeff_g_i, cfg_coeff_b_i, cfg_shift_i));
          prev = d;
        end
        line_end();
      end
      compare_stream("rand_frame");
      eof_frame();
    end

    // bypass BE with backpressure: first held, three dropped
    cfg_format_i = 3'b100;
    pix_ready_i = 1'b0;
    sof_frame();
    d0 = $urandom_range(0, 255); d1 = $urandom_range(0, 255);
    exp_q.push_back(16'(d0 * 256 + d1));
    send(DW'(d0)); send(DW'(d1));
    for (int i = 0; i < 6; i++) send(DW'($urandom_range(0, 255)));
    line_end();
    cyc(4);
    check("bp_held_valid", pix_valid_o, 1);
    check("bp_held_data", pix_data_o, exp_q[0]);
    check("bp_ovf", ovf_o, 1);
    pix_ready_i = 1'b1;
    cyc(2);
    check("bp_drained", pix_valid_o, 0);
    compare_stream("bp_stream");
    check("bp_ovf_sticky", ovf_o, 1);
    eof_frame();
    check("bp_ovf_pre_sof", ovf_o, 1);
    sof_frame();
    check("bp_ovf_clr_sof", ovf_o, 0);
    eof_frame();

    // frame drop: val=2 over 6 frames keeps frames 0 and 3
    enable_cycle();
    cfg_format_i = 3'b110;
    cfg_framedrop_en_i = 1'b1;
    cfg_framedrop_val_i = 6'd2;
    fd0 = fd_cnt;
    for (int f = 0; f < 6; f++) begin
      sof_frame();
      for (int i = 0; i < 2; i++) begin
        d = $urandom_range(0, 4095);
        send(DW'(d));
        if ((f % 3) == 0) exp_q.push_back(16'(d));
      end
      line_end();
      eof_frame();
    end
    compare_stream("framedrop");
    check("framedrop_fdone", fd_cnt - fd0, 6);

    // slice window with optional decimation
    cfg_framedrop_en_i = 1'b0;
    cfg_slice_en_i = 1'b1;
    cfg_llx_i = 16'd2; cfg_urx_i = 16'd3; cfg_lly_i = 16'd1; cfg_ury_i = 16'd1;
    cfg_rowlen_i = 16'd7;
    cfg_decim_i = 4'b0001;
    sof_frame();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 8; c++) begin
        send(DW'(256 + r * 16 + c));
        if (c >= 2 && c <= 3 && r == 1) begin
`ifdef CAM_PIX_DECIM_EN
          if ((c % 2) == 0) exp_q.push_back(16'(256 + r * 16 + c));
`else
          exp_q.push_back(16'(256 + r * 16 + c));
`endif
        end
      end
      line_end();
    end
    compare_stream("slice");
    eof_frame();
    cfg_slice_en_i = 1'b0;
    cfg_rowlen_i = 16'hFFFF;
    cfg_decim_i = 4'd0;

    // enable dropped mid-line
    sof_frame();
    for (int i = 0; i < 3; i++) send(DW'($urandom_range(0, 4095)));
    cfg_en_i = 1'b0;
    for (int i = 0; i < 4; i++) send(DW'($urandom_range(0, 4095)));
    check("endrop_valid_4cyc", pix_valid_o, 0);
    for (int i = 0; i < 3; i++) send(DW'($urandom_range(0, 4095)));
    check("endrop_valid_later", pix_valid_o, 0);
    line_end();
    got_q.delete();
    cfg_en_i = 1'b1;
    cyc(4);
    for (int i = 0; i < 4; i++) send(DW'($urandom_range(0, 4095)));
    line_end();
    cyc(6);
    check("endrop_no_out_before_sof", got_q.size(), 0);
    fd0 = fd_cnt;
    eof_frame();
    check("endrop_no_fdone_inactive", fd_cnt - fd0, 0);
    sof_frame();
    for (int i = 0; i < 2; i++) begin
      d = $urandom_range(0, 4095);
      send(DW'(d));
      exp_q.push_back(16'(d));
    end
    line_end();
    compare_stream("endrop_resume");
    eof_frame();

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
